// File: rtl/gpio_pkg.sv
// Register map and address-width rule shared by the GPIO block and its bench.
package gpio_pkg;

    localparam int NUM_REGS = 8;

    function automatic int addr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W = addr_bits(NUM_REGS);

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit pad synchroniser: each bit passes through STAGES flops, reset to 0.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_edge_ctrl.sv
// Avalon-MM GPIO port: output/direction registers, set/clear ops, per-bit edge capture and irq.
// Reads return one cycle after the address; writes take effect on the next clock edge.
module gpio_edge_ctrl
    import gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] RISE_RESET  = '1,
    parameter logic [WIDTH-1:0] FALL_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic             clr_strobe;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] out_reg, dir_reg, mask_reg, cap_reg, rise_reg, fall_reg;
    logic [31:0]      rd_mux;

    assign wr         = chipselect & ~write_n;
    assign clr_strobe = wr && (address == ADDR_EDGE);
    assign wdat       = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic unused_wdat_hi;
            assign unused_wdat_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_in)
    );

    assign edge_event = (sync_in & ~prev & rise_reg) | (~sync_in & prev & fall_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            out_reg  <= OUT_RESET;
            dir_reg  <= '0;
            mask_reg <= '0;
            cap_reg  <= '0;
            rise_reg <= RISE_RESET;
            fall_reg <= FALL_RESET;
            readdata <= '0;
        end else begin
            prev     <= sync_in;
            readdata <= rd_mux;
            // A new edge is ORed in after the clear so a coincident event survives.
            cap_reg  <= (cap_reg & ~(clr_strobe ? wdat : '0)) | edge_event;
            if (wr) begin
                case (address)
                    ADDR_DATA:   out_reg  <= wdat;
                    ADDR_DIR:    dir_reg  <= wdat;
                    ADDR_MASK:   mask_reg <= wdat;
                    ADDR_RISE:   rise_reg <= wdat;
                    ADDR_FALL:   fall_reg <= wdat;
                    ADDR_OUTSET: out_reg  <= out_reg | wdat;
                    ADDR_OUTCLR: out_reg  <= out_reg & ~wdat;
                    default: ;
                endcase
            end
        end
    end

    // DATA reads the pads, never the output register.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = sync_in;
            ADDR_DIR:  rd_mux[WIDTH-1:0] = dir_reg;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask_reg;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = cap_reg;
            ADDR_RISE: rd_mux[WIDTH-1:0] = rise_reg;
            ADDR_FALL: rd_mux[WIDTH-1:0] = fall_reg;
            default: ;
        endcase
    end

    assign out_port = out_reg;
    assign oe       = dir_reg;
    assign irq      = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_gpio_edge_ctrl.sv
// Bench for gpio_edge_ctrl at WIDTH=8, SYNC_STAGES=2, OUT_RESET=0x5A.
module tb_gpio_edge_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;
    vec_t vecs[6];

    gpio_edge_ctrl #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .OUT_RESET   (8'h5A),
        .RISE_RESET  (8'hFF),
        .FALL_RESET  (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string name, input logic [31:0] e);
        exp_t got;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb.push_back('{name, e});
        tick();
        chipselect = 1'b0;
        got = sb.pop_front();
        check(got.name, readdata, got.val);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[1] = '{3'd2, 32'h0000_01FF, 32'h0000_00FF};
        vecs[2] = '{3'd4, 32'h0000_000F, 32'h0000_000F};
        vecs[3] = '{3'd5, 32'h0000_00A0, 32'h0000_00A0};
        vecs[4] = '{3'd6, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{3'd7, 32'h0000_0000, 32'h0000_0000};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        ticks(3);
        reset_n = 1'b1;
        tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_out_port", {24'h0, out_port}, 32'h5A);
        check("rst_oe", {24'h0, oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd(3'd4, "rst_rise_en", 32'hFF);
        rd(3'd5, "rst_fall_en", 32'h00);
        rd(3'd3, "rst_capture", 32'h00);
        rd(3'd2, "rst_mask", 32'h00);

        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, $sformatf("vec%0d_readback", i), vecs[i].rexp);
        end
        check("dir_oe", {24'h0, oe}, 32'hFF);

        // Rising edge on bit 0: irq exactly SYNC_STAGES+1 cycles after the change.
        wr(3'd4, 32'h01); wr(3'd5, 32'h00); wr(3'd3, 32'hFF); wr(3'd2, 32'h01);
        in_port[0] = 1'b1;
        ticks(2);
        check("rise_irq_early", {31'h0, irq}, 32'h0);
        tick();
        check("rise_irq", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h01);
        check("w1c_irq_clear", {31'h0, irq}, 32'h0);

        // Falling-only on bit 2.
        wr(3'd4, 32'h00); wr(3'd5, 32'h04);
        in_port[2] = 1'b1;
        ticks(5);
        rd(3'd3, "fall_no_rise", 32'h00);
        in_port[2] = 1'b0;
        ticks(5);
        rd(3'd3, "fall_capture", 32'h04);
        check("fall_unmasked_irq", {31'h0, irq}, 32'h0);
        wr(3'd3, 32'h04);

        // W1C of bit 5 lands on the same edge that captures its new event.
        wr(3'd4, 32'h20);
        in_port[5] = 1'b1;
        ticks(2);
        wr(3'd3, 32'h20);
        rd(3'd3, "collision_set_wins", 32'h20);
        wr(3'd3, 32'h20);
        rd(3'd3, "w1c_no_event", 32'h00);

        wr(3'd0, 32'hF0); wr(3'd6, 32'h03); wr(3'd7, 32'h30);
        check("out_ops", {24'h0, out_port}, 32'hC3);
        rd(3'd6, "outset_reads0", 32'h0);
        rd(3'd0, "data_reads_pads", 32'h21);

        in_port = 8'hA5;
        ticks(3);
        rd(3'd0, "read_width", 32'h0000_00A5);

        // Pending capture on bit 5, then unmask it.
        in_port = 8'h85;
        ticks(3);
        in_port = 8'hA5;
        ticks(4);
        check("pending_masked_irq", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h20);
        check("mask_irq", {31'h0, irq}, 32'h1);

        // Asynchronous reset mid-cycle with readdata holding the pads.
        rd(3'd0, "pre_reset_read", 32'hA5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_irq", {31'h0, irq}, 32'h0);
        check("arst_oe", {24'h0, oe}, 32'h0);
        check("arst_readdata", readdata, 32'h0);
        check("arst_out_port", {24'h0, out_port}, 32'h5A);
        tick();
        reset_n = 1'b1;
        ticks(4);
        rd(3'd3, "release_high_pads", 32'hA5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
